reg_write_arbiter: RTL and testbench

//  Shares the register-bank write port between the SPI host write path and one on-chip requester, e.g. a PID loop.

---
 rtl/reg_write_arbiter_if.sv | 34 +++
 rtl/reg_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Register-bank write arbiter bus: SPI host write strobe, local requester
// handshake, watchdog enable, and the single arbitrated bank write port.
interface reg_write_arbiter_if;
    logic        host_wr_stb;
    logic [9:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        loc_valid;
    logic [9:0]  loc_addr;
    logic [15:0] loc_data;
    logic        loc_ready;
    logic        wdog_en;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        host_ovf;
    logic        loc_reject;
    logic        wdog_tripped;

    // Requester / bank side: drives the requests, observes grants and writes
    modport master (
        output host_wr_stb, host_wr_addr, host_wr_data,
        output loc_valid, loc_addr, loc_data, wdog_en,
        input  loc_ready, wr_en, wr_addr, wr_data,
        input  host_ovf, loc_reject, wdog_tripped
    );

    // Arbiter side
    modport slave (
        input  host_wr_stb, host_wr_addr, host_wr_data,
        input  loc_valid, loc_addr, loc_data, wdog_en,
        output loc_ready, wr_en, wr_addr, wr_data,
        output host_ovf, loc_reject, wdog_tripped
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the register-bank write port between the SPI host path (1-entry
// buffer) and one local requester, with a host-silence watchdog that forces
// a single all-stop write. At most one registered write per cycle.
module reg_write_arbiter #(
    parameter logic [31:0] WDOG_CYCLES    = 32'd5_000_000,
    parameter logic [3:0]  HOST_BURST_MAX = 4'd4,
    parameter logic [9:0]  ALLSTOP_ADDR   = 10'd40,
    parameter logic [15:0] ALLSTOP_DATA   = 16'h001F,
    parameter logic [9:0]  LOCAL_ADDR_LO  = 10'd33,
    parameter logic [9:0]  LOCAL_ADDR_HI  = 10'd36
) (
    input  logic               SYS_CLK,
    input  logic               RST_N,
    reg_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {ST_RUN, ST_FIRE, ST_TRIPPED} wdog_state_t;

    wdog_state_t r_state;
    logic        r_hb_full;
    logic [9:0]  r_hb_addr;
    logic [15:0] r_hb_data;
    logic [3:0]  r_streak;
    logic [31:0] r_wdog_cnt;
    logic        r_wr_en;
    logic [9:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_host_ovf;
    logic        r_loc_reject;
    logic        r_wdog_tripped;

    logic w_fire;
    logic w_loc_pri;
    logic w_gnt_host;
    logic w_gnt_loc;
    logic w_in_win;
    logic w_wdog_hit;

    // Grant decode. FIRE beats everything; a local request that has waited
    // out a full host burst beats the host buffer; otherwise host first.
    // Local grant is masked during reset so loc_ready reads 0 immediately.
    assign w_fire     = (r_state == ST_FIRE);
    assign w_loc_pri  = bus.loc_valid && (r_streak == HOST_BURST_MAX);
    assign w_gnt_host = !w_fire && !w_loc_pri && r_hb_full;
    assign w_gnt_loc  = RST_N && !w_fire && bus.loc_valid && (w_loc_pri || !r_hb_full);
    assign w_in_win   = (bus.loc_addr >= LOCAL_ADDR_LO) && (bus.loc_addr <= LOCAL_ADDR_HI);
    assign w_wdog_hit = (r_wdog_cnt == WDOG_CYCLES - 32'd1);

    assign bus.loc_ready    = w_gnt_loc;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.host_ovf     = r_host_ovf;
    assign bus.loc_reject   = r_loc_reject;
    assign bus.wdog_tripped = r_wdog_tripped;

    // Host buffer: a strobe always (re)loads it; a grant without a strobe empties it
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hb_full <= 1'b0;
            r_hb_addr <= '0;
            r_hb_data <= '0;
        end else if (bus.host_wr_stb) begin
            r_hb_full <= 1'b1;
            r_hb_addr <= bus.host_wr_addr;
            r_hb_data <= bus.host_wr_data;
        end else if (w_gnt_host) begin
            r_hb_full <= 1'b0;
        end
    end

    // Streak of host grants taken while local waits; saturates at the burst limit
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N)
            r_streak <= '0;
        else if (!bus.loc_valid || w_gnt_loc)
            r_streak <= '0;
        else if (w_gnt_host && (r_streak != HOST_BURST_MAX))
            r_streak <= r_streak + 4'd1;
    end

    // Host-silence counter; any host strobe or disabling the watchdog restarts it
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N)
            r_wdog_cnt <= '0;
        else if (bus.host_wr_stb || !bus.wdog_en)
            r_wdog_cnt <= '0;
        else if (r_wdog_cnt != '1)
            r_wdog_cnt <= r_wdog_cnt + 32'd1;
    end

    // Watchdog FSM: RUN -> FIRE (one cycle) -> TRIPPED until the host speaks again
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ST_RUN;
            r_wdog_tripped <= 1'b0;
        end else if (!bus.wdog_en) begin
            r_state        <= ST_RUN;
            r_wdog_tripped <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // a strobe on the trigger cycle wins: counter restarts instead
                    if (!bus.host_wr_stb && w_wdog_hit)
                        r_state <= ST_FIRE;
                end
                ST_FIRE: begin
                    r_state        <= ST_TRIPPED;
                    r_wdog_tripped <= 1'b1;
                end
                ST_TRIPPED: begin
                    if (bus.host_wr_stb) begin
                        r_state        <= ST_RUN;
                        r_wdog_tripped <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Registered bank write port plus the overflow / reject status pulses
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_host_ovf   <= 1'b0;
            r_loc_reject <= 1'b0;
        end else begin
            r_wr_en      <= w_fire || w_gnt_host || (w_gnt_loc && w_in_win);
            r_loc_reject <= w_gnt_loc && !w_in_win;
            r_host_ovf   <= bus.host_wr_stb && r_hb_full && !w_gnt_host;
            if (w_fire) begin
                r_wr_addr <= ALLSTOP_ADDR;
                r_wr_data <= ALLSTOP_DATA;
            end else if (w_gnt_host) begin
                r_wr_addr <= r_hb_addr;
                r_wr_data <= r_hb_data;
            end else if (w_gnt_loc && w_in_win) begin
                r_wr_addr <= bus.loc_addr;
                r_wr_data <= bus.loc_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: expected bank writes are queued as
// stimulus is driven and popped by a monitor whenever wr_en is seen.
module tb_reg_write_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [25:0] exp_q[$];

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(
        .WDOG_CYCLES    (32'd16),
        .HOST_BURST_MAX (4'd4),
        .ALLSTOP_ADDR   (10'd40),
        .ALLSTOP_DATA   (16'h001F),
        .LOCAL_ADDR_LO  (10'd33),
        .LOCAL_ADDR_HI  (10'd36)
    ) dut (
        .SYS_CLK (clk),
        .RST_N   (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic [9:0] a, input logic [15:0] d);
        bus.host_wr_stb  = 1'b1;
        bus.host_wr_addr = a;
        bus.host_wr_data = d;
    endtask

    // Scoreboard monitor: every bank write must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_q.size() == 0)
                chk("wr_unexpected", {31'd0, bus.wr_en}, 32'd0);
            else
                chk("wr_addr_data", {6'd0, bus.wr_addr, bus.wr_data}, {6'd0, exp_q.pop_front()});
        end
    end

    initial begin
        logic [9:0] ba[4];
        logic       inwin;
        int         k;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.host_wr_stb = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        bus.loc_valid = 1'b0;   bus.loc_addr = '0;     bus.loc_data = '0;
        bus.wdog_en = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {27'd0, bus.wr_en, bus.host_ovf, bus.loc_reject, bus.wdog_tripped, bus.loc_ready}, 32'd0);
        chk("reset_wr_bus", {6'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single host write, 2-cycle latency
        host(10'd25, 16'h0100); push(10'd25, 16'h0100);
        @(negedge clk); chk("t1_lat0", {31'd0, bus.wr_en}, 32'd0);
        cyc(); bus.host_wr_stb = 1'b0;
        @(negedge clk); chk("t1_lat1", {31'd0, bus.wr_en}, 32'd0);
        cyc();
        @(negedge clk); chk("t1_lat2", {31'd0, bus.wr_en}, 32'd1);
        chk("t1_no_ovf", {31'd0, bus.host_ovf}, 32'd0);
        cyc();

        // Host burst vs pending local; the 5th strobe lands on the local-priority
        // cycle, so the buffered 4th-after-first write is overwritten
        host(10'd100, 16'h1000); push(10'd100, 16'h1000);
        cyc();
        bus.loc_valid = 1'b1; bus.loc_addr = 10'd34; bus.loc_data = 16'hBEEF;
        for (int i = 1; i <= 4; i++) begin
            host(10'd100 + 10'(i), 16'h1000 + 16'(i));
            if (i < 4) push(10'd100 + 10'(i), 16'h1000 + 16'(i));
            @(negedge clk); chk("t2_host_wins", {31'd0, bus.loc_ready}, 32'd0);
            cyc();
        end
        host(10'd105, 16'h1005); push(10'd34, 16'hBEEF); push(10'd105, 16'h1005);
        @(negedge clk); chk("t2_local_after_4", {31'd0, bus.loc_ready}, 32'd1);
        chk("t2_reload_no_ovf", {31'd0, bus.host_ovf}, 32'd0);
        cyc(); bus.host_wr_stb = 1'b0; bus.loc_valid = 1'b0;
        @(negedge clk); chk("t3_ovf", {31'd0, bus.host_ovf}, 32'd1);
        chk("t3_no_reject", {31'd0, bus.loc_reject}, 32'd0);
        cyc();
        @(negedge clk); chk("t3_ovf_pulse", {31'd0, bus.host_ovf}, 32'd0);
        repeat (3) cyc();

        // Local write outside the window is consumed and rejected
        bus.loc_valid = 1'b1; bus.loc_addr = 10'd29; bus.loc_data = 16'h1234;
        @(negedge clk); chk("t4_ready", {31'd0, bus.loc_ready}, 32'd1);
        cyc(); bus.loc_valid = 1'b0;
        @(negedge clk); chk("t4_reject", {31'd0, bus.loc_reject}, 32'd1);
        chk("t4_no_wr", {31'd0, bus.wr_en}, 32'd0);
        cyc();
        // Window edges
        ba[0] = 10'd32; ba[1] = 10'd33; ba[2] = 10'd36; ba[3] = 10'd37;
        for (int i = 0; i < 4; i++) begin
            inwin = (ba[i] >= 10'd33) && (ba[i] <= 10'd36);
            bus.loc_valid = 1'b1; bus.loc_addr = ba[i]; bus.loc_data = 16'hA000 + 16'(i);
            if (inwin) push(ba[i], 16'hA000 + 16'(i));
            @(negedge clk); chk("t4_edge_ready", {31'd0, bus.loc_ready}, 32'd1);
            cyc(); bus.loc_valid = 1'b0;
            @(negedge clk); chk("t4_edge_reject", {31'd0, bus.loc_reject}, {31'd0, !inwin});
            cyc();
        end

        // Watchdog: fires once 16 cycles of silence after enable
        bus.wdog_en = 1'b1; push(10'd40, 16'h001F);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (bus.wdog_tripped) break;
            cyc();
            k++;
        end
        chk("t5_fire_time", k, 32'd17);
        cyc();
        repeat (40) cyc();
        @(negedge clk); chk("t5_tripped_held", {31'd0, bus.wdog_tripped}, 32'd1);
        cyc();
        host(10'd200, 16'h5555); push(10'd200, 16'h5555);
        @(negedge clk); chk("t5_tripped_until_edge", {31'd0, bus.wdog_tripped}, 32'd1);
        cyc(); bus.host_wr_stb = 1'b0;
        @(negedge clk); chk("t5_tripped_clear", {31'd0, bus.wdog_tripped}, 32'd0);
        bus.wdog_en = 1'b0;
        repeat (3) cyc();

        // Async reset with a write on the port and a local request pending
        host(10'd300, 16'h3030);
        cyc(); bus.host_wr_stb = 1'b0;
        bus.loc_valid = 1'b1; bus.loc_addr = 10'd35; bus.loc_data = 16'h3535;
        @(negedge clk); chk("t6_local_pending", {31'd0, bus.loc_ready}, 32'd0);
        cyc();
        chk("t6_wr_before_rst", {31'd0, bus.wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", {27'd0, bus.wr_en, bus.host_ovf, bus.loc_reject, bus.wdog_tripped, bus.loc_ready}, 32'd0);
        chk("t6_rst_wr_bus", {6'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.loc_valid = 1'b0;
        rst_n = 1'b1;
        repeat (6) cyc();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
